// File: rtl/dallanma_birimi_r_if.sv
// dallanma_birimi_r_if: execute-stage branch operands in, fetch redirect and predictor update out
interface dallanma_birimi_r_if #(parameter int XLEN = 32);
    logic [3:0]      islem_kod_i;
    logic [XLEN-1:0] islem_ps_i;
    logic [XLEN-1:0] islem_islec_i;
    logic [XLEN-1:0] islem_anlik_i;
    logic            islem_atladi_i;
    logic            islem_rvc_i;
    logic            alu_esittir_i;
    logic            alu_kucuktur_i;
    logic            alu_kucuktur_isaretsiz_i;
    logic [XLEN-1:0] g1_ps_o;
    logic            g1_ps_gecerli_o;
    logic [XLEN-1:0] g2_ps_o;
    logic [XLEN-1:0] g2_hedef_ps_o;
    logic            g2_guncelle_o;
    logic            g2_atladi_o;
    logic            g2_hatali_tahmin_o;
    logic [XLEN-1:0] ps_atlamadi_o;

    modport master (
        output islem_kod_i, islem_ps_i, islem_islec_i, islem_anlik_i, islem_atladi_i, islem_rvc_i,
               alu_esittir_i, alu_kucuktur_i, alu_kucuktur_isaretsiz_i,
        input  g1_ps_o, g1_ps_gecerli_o, g2_ps_o, g2_hedef_ps_o, g2_guncelle_o, g2_atladi_o,
               g2_hatali_tahmin_o, ps_atlamadi_o
    );

    modport slave (
        input  islem_kod_i, islem_ps_i, islem_islec_i, islem_anlik_i, islem_atladi_i, islem_rvc_i,
               alu_esittir_i, alu_kucuktur_i, alu_kucuktur_isaretsiz_i,
        output g1_ps_o, g1_ps_gecerli_o, g2_ps_o, g2_hedef_ps_o, g2_guncelle_o, g2_atladi_o,
               g2_hatali_tahmin_o, ps_atlamadi_o
    );
endinterface

// File: rtl/dallanma_birimi_r.sv
// dallanma_birimi_r: resolves branches/jumps, drives same-cycle fetch redirect and registered predictor update
module dallanma_birimi_r #(
    parameter int XLEN = 32
) (
    input logic                 clk_i,
    input logic                 rstn_i,
    dallanma_birimi_r_if.slave  bus
);
    localparam logic [3:0] DAL_YOK  = 4'd0;
    localparam logic [3:0] DAL_EQ   = 4'd1;
    localparam logic [3:0] DAL_NE   = 4'd2;
    localparam logic [3:0] DAL_LT   = 4'd3;
    localparam logic [3:0] DAL_GE   = 4'd4;
    localparam logic [3:0] DAL_LTU  = 4'd5;
    localparam logic [3:0] DAL_GEU  = 4'd6;
    localparam logic [3:0] DAL_JAL  = 4'd7;
    localparam logic [3:0] DAL_JALR = 4'd8;

    logic            w_kosullu;
    logic            w_jal;
    logic            w_jalr;
    logic            w_gecerli;
    logic            w_atladi;
    logic            w_hatali;
    logic [XLEN-1:0] w_ps_atlamadi;
    logic [XLEN-1:0] w_jalr_toplam;
    logic [XLEN-1:0] w_hedef;

    logic [XLEN-1:0] r_g2_ps;
    logic [XLEN-1:0] r_g2_hedef;
    logic            r_g2_guncelle;
    logic            r_g2_atladi;
    logic            r_g2_hatali;

    always_comb begin
        w_kosullu     = (bus.islem_kod_i >= DAL_EQ) && (bus.islem_kod_i <= DAL_GEU);
        w_jal         = bus.islem_kod_i == DAL_JAL;
        w_jalr        = bus.islem_kod_i == DAL_JALR;
        w_gecerli     = w_kosullu || w_jal || w_jalr;
        w_atladi      = (bus.islem_kod_i == DAL_EQ)  ?  bus.alu_esittir_i :
                        (bus.islem_kod_i == DAL_NE)  ? !bus.alu_esittir_i :
                        (bus.islem_kod_i == DAL_LT)  ?  bus.alu_kucuktur_i :
                        (bus.islem_kod_i == DAL_GE)  ? !bus.alu_kucuktur_i :
                        (bus.islem_kod_i == DAL_LTU) ?  bus.alu_kucuktur_isaretsiz_i :
                        (bus.islem_kod_i == DAL_GEU) ? !bus.alu_kucuktur_isaretsiz_i :
                        (w_jal || w_jalr);
        w_ps_atlamadi = bus.islem_ps_i + XLEN'(bus.islem_rvc_i ? 3'd2 : 3'd4);
        w_jalr_toplam = bus.islem_islec_i + bus.islem_anlik_i;
        w_hedef       = w_jalr ? {w_jalr_toplam[XLEN-1:1], 1'b0} :
                        (w_kosullu || w_jal) ? bus.islem_ps_i + bus.islem_anlik_i : w_ps_atlamadi;
        // JALR has no predicted target to compare against, so it always redirects
        w_hatali      = w_jalr || ((w_kosullu || w_jal) && (w_atladi != bus.islem_atladi_i));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_g2_ps       <= '0;
            r_g2_hedef    <= '0;
            r_g2_guncelle <= 1'b0;
            r_g2_atladi   <= 1'b0;
            r_g2_hatali   <= 1'b0;
        end else begin
            r_g2_ps       <= bus.islem_ps_i;
            r_g2_hedef    <= w_hedef;
            r_g2_guncelle <= w_gecerli;
            r_g2_atladi   <= w_atladi;
            r_g2_hatali   <= w_hatali;
        end
    end

    assign bus.g1_ps_o            = w_atladi ? w_hedef : w_ps_atlamadi;
    assign bus.g1_ps_gecerli_o    = w_hatali;
    assign bus.ps_atlamadi_o      = w_ps_atlamadi;
    assign bus.g2_ps_o            = r_g2_ps;
    assign bus.g2_hedef_ps_o      = r_g2_hedef;
    assign bus.g2_guncelle_o      = r_g2_guncelle;
    assign bus.g2_atladi_o        = r_g2_atladi;
    assign bus.g2_hatali_tahmin_o = r_g2_hatali;
endmodule

// File: tb/tb_dallanma_birimi_r.sv
// tb_dallanma_birimi_r: directed table, random vectors against a rule-level model, async reset sequence
module tb_dallanma_birimi_r;
    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk_i = ~clk_i;

    dallanma_birimi_r_if bus ();
    dallanma_birimi_r dut (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus));

    typedef struct packed {
        logic [3:0]  kod;
        logic [31:0] ps;
        logic [31:0] islec;
        logic [31:0] anlik;
        logic        at;
        logic        rvc;
        logic        eq;
        logic        lt;
        logic        ltu;
    } giris_t;

    typedef struct packed {
        logic [31:0] g1_ps;
        logic        g1_v;
        logic [31:0] ft;
        logic [31:0] hedef;
        logic        atl;
        logic        hat;
        logic        gun;
    } cikis_t;

    typedef struct packed {
        giris_t g;
        cikis_t c;
    } vektor_t;

    vektor_t tablo [12];

    function automatic cikis_t model(input giris_t g);
        cikis_t c;
        logic   taken;
        logic   valid;
        valid = (g.kod >= 1) && (g.kod <= 8);
        case (g.kod)
            4'd1: taken = g.eq;
            4'd2: taken = !g.eq;
            4'd3: taken = g.lt;
            4'd4: taken = !g.lt;
            4'd5: taken = g.ltu;
            4'd6: taken = !g.ltu;
            4'd7, 4'd8: taken = 1'b1;
            default: taken = 1'b0;
        endcase
        c.ft    = g.ps + (g.rvc ? 32'd2 : 32'd4);
        c.hedef = (g.kod == 8) ? ((g.islec + g.anlik) & 32'hFFFF_FFFE) : valid ? g.ps + g.anlik : c.ft;
        c.atl   = taken;
        c.hat   = (g.kod == 8) ? 1'b1 : valid ? (taken != g.at) : 1'b0;
        c.gun   = valid;
        c.g1_v  = c.hat;
        c.g1_ps = taken ? c.hedef : c.ft;
        return c;
    endfunction

    task automatic check(input string ad, input logic [31:0] a, input logic [31:0] e);
        n_assert++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", ad, a, e);
        end
    endtask

    task automatic drive(input giris_t g);
        bus.islem_kod_i              = g.kod;
        bus.islem_ps_i               = g.ps;
        bus.islem_islec_i            = g.islec;
        bus.islem_anlik_i            = g.anlik;
        bus.islem_atladi_i           = g.at;
        bus.islem_rvc_i              = g.rvc;
        bus.alu_esittir_i            = g.eq;
        bus.alu_kucuktur_i           = g.lt;
        bus.alu_kucuktur_isaretsiz_i = g.ltu;
    endtask

    task automatic run_vec(input giris_t g, input cikis_t c);
        drive(g);
        #1;
        check("g1_ps", bus.g1_ps_o, c.g1_ps);
        check("g1_gecerli", 32'(bus.g1_ps_gecerli_o), 32'(c.g1_v));
        check("ps_atlamadi", bus.ps_atlamadi_o, c.ft);
        @(posedge clk_i);
        #1;
        check("g2_guncelle", 32'(bus.g2_guncelle_o), 32'(c.gun));
        check("g2_ps", bus.g2_ps_o, g.ps);
        check("g2_hedef", bus.g2_hedef_ps_o, c.hedef);
        check("g2_atladi", 32'(bus.g2_atladi_o), 32'(c.atl));
        check("g2_hatali", 32'(bus.g2_hatali_tahmin_o), 32'(c.hat));
    endtask

    task automatic check_g2_zero(input string ad);
        check({ad, "_guncelle"}, 32'(bus.g2_guncelle_o), 32'd0);
        check({ad, "_ps"}, bus.g2_ps_o, 32'd0);
        check({ad, "_hedef"}, bus.g2_hedef_ps_o, 32'd0);
        check({ad, "_atladi"}, 32'(bus.g2_atladi_o), 32'd0);
        check({ad, "_hatali"}, 32'(bus.g2_hatali_tahmin_o), 32'd0);
    endtask

    initial begin
        giris_t g;
        cikis_t c;
        //            kod    ps            islec         anlik         at    rvc   eq    lt    ltu      g1_ps         v     ft            hedef         atl   hat   gun
        tablo[0]  = '{'{4'd1,  32'h0040_0000, 32'h0,        32'h10,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, '{32'h0040_0010, 1'b0, 32'h0040_0004, 32'h0040_0010, 1'b1, 1'b0, 1'b1}};
        tablo[1]  = '{'{4'd2,  32'h0040_0000, 32'h0,        32'h8,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, '{32'h0040_0008, 1'b1, 32'h0040_0004, 32'h0040_0008, 1'b1, 1'b1, 1'b1}};
        tablo[2]  = '{'{4'd3,  32'h0040_0000, 32'h0,        32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}, '{32'h003F_FFFC, 1'b1, 32'h0040_0004, 32'h003F_FFFC, 1'b1, 1'b1, 1'b1}};
        tablo[3]  = '{'{4'd6,  32'h0040_0000, 32'h0,        32'h40,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, '{32'h0040_0040, 1'b0, 32'h0040_0004, 32'h0040_0040, 1'b1, 1'b0, 1'b1}};
        tablo[4]  = '{'{4'd4,  32'h0040_0000, 32'h0,        32'h10,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, '{32'h0040_0010, 1'b1, 32'h0040_0002, 32'h0040_0010, 1'b1, 1'b1, 1'b1}};
        tablo[5]  = '{'{4'd7,  32'h0040_0000, 32'h0,        32'h20,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, '{32'h0040_0020, 1'b0, 32'h0040_0004, 32'h0040_0020, 1'b1, 1'b0, 1'b1}};
        tablo[6]  = '{'{4'd8,  32'h0040_0000, 32'h0000_1001, 32'h20,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, '{32'h0000_1020, 1'b1, 32'h0040_0004, 32'h0000_1020, 1'b1, 1'b1, 1'b1}};
        tablo[7]  = '{'{4'd0,  32'h0040_0000, 32'h0,        32'h10,       1'b1, 1'b0, 1'b1, 1'b1, 1'b1}, '{32'h0040_0004, 1'b0, 32'h0040_0004, 32'h0040_0004, 1'b0, 1'b0, 1'b0}};
        tablo[8]  = '{'{4'd12, 32'h0040_0100, 32'h0,        32'h10,       1'b0, 1'b0, 1'b1, 1'b1, 1'b1}, '{32'h0040_0104, 1'b0, 32'h0040_0104, 32'h0040_0104, 1'b0, 1'b0, 1'b0}};
        tablo[9]  = '{'{4'd1,  32'h0040_0000, 32'h0,        32'h10,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, '{32'h0040_0004, 1'b1, 32'h0040_0004, 32'h0040_0010, 1'b0, 1'b1, 1'b1}};
        tablo[10] = '{'{4'd5,  32'hFFFF_FFFE, 32'h0,        32'h4,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1}, '{32'h0000_0002, 1'b0, 32'h0000_0000, 32'h0000_0002, 1'b1, 1'b0, 1'b1}};
        tablo[11] = '{'{4'd3,  32'h0040_0000, 32'h0,        32'h10,       1'b0, 1'b0, 1'b1, 1'b0, 1'b1}, '{32'h0040_0004, 1'b0, 32'h0040_0004, 32'h0040_0010, 1'b0, 1'b0, 1'b1}};

        drive(tablo[0].g);
        #12;
        check_g2_zero("reset");
        check("reset_g1_ps", bus.g1_ps_o, 32'h0040_0010);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 12; i++) run_vec(tablo[i].g, tablo[i].c);

        for (int i = 0; i < 300; i++) begin
            g.kod   = 4'($urandom_range(0, 15));
            g.ps    = $urandom & 32'hFFFF_FFFE;
            g.islec = $urandom;
            g.anlik = $urandom;
            g.at    = 1'($urandom);
            g.rvc   = 1'($urandom);
            g.eq    = 1'($urandom);
            g.lt    = 1'($urandom);
            g.ltu   = 1'($urandom);
            c = model(g);
            run_vec(g, c);
        end

        // Async reset between edges must drop a pending update at once
        run_vec(tablo[5].g, tablo[5].c);
        #3;
        rstn_i = 1'b0;
        #1;
        check_g2_zero("async_rst");
        check("async_rst_g1_ps", bus.g1_ps_o, 32'h0040_0020);
        @(posedge clk_i);
        #1;
        check_g2_zero("rst_held");
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst_release_guncelle", 32'(bus.g2_guncelle_o), 32'd1);
        check("rst_release_hedef", bus.g2_hedef_ps_o, 32'h0040_0020);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
